// File: rtl/div_if.sv
// Operand/result bundle between the control unit (master) and the divider (slave).
interface div_if;
  logic        div_init;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_stop;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output div_init, dividend, divisor,
    input  div_stop, div_zero, hi_out, lo_out
  );

  modport slave (
    input  div_init, dividend, divisor,
    output div_stop, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/div.sv
// Sequential 32-bit signed restoring divider: HI = remainder, LO = quotient (MIPS DIV).
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor completes on the next edge with div_zero set.
module div (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, HOLD} state_t;

  state_t      state;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] q;
  logic [31:0] d;
  logic [31:0] r;
  logic [5:0]  cnt;
`ifdef DIV_ZERO_DETECT_EN
  logic        zero_pend;
`endif

  logic [32:0] shift_r;
  logic [32:0] diff_r;
  logic [31:0] shift_q;
  logic        take;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // The stored remainder is always below D, so the 33-bit step value never
  // overflows and the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    shift_r = {r, q[31]};
    shift_q = {q[30:0], 1'b0};
    diff_r  = shift_r - {1'b0, d};
    take    = ~diff_r[32];
  end

`ifndef DIV_ZERO_DETECT_EN
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      q            <= '0;
      d            <= '0;
      r            <= '0;
      cnt          <= '0;
      bus.div_stop <= 1'b0;
      bus.hi_out   <= '0;
      bus.lo_out   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      zero_pend    <= 1'b0;
      bus.div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.div_stop <= 1'b0;
          if (bus.div_init) begin
            sign_a <= bus.dividend[31];
            sign_b <= bus.divisor[31];
            q      <= mag(bus.dividend);
            d      <= mag(bus.divisor);
            r      <= '0;
            cnt    <= '0;
`ifdef DIV_ZERO_DETECT_EN
            bus.div_zero <= 1'b0;
            zero_pend    <= (bus.divisor == '0);
            state        <= (bus.divisor == '0) ? FIX : RUN;
`else
            state  <= RUN;
`endif
          end
        end

        RUN: begin
          if (!bus.div_init) begin
            state <= IDLE;
          end else begin
            r   <= take ? diff_r[31:0] : shift_r[31:0];
            q   <= {shift_q[31:1], take};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31)
              state <= FIX;
          end
        end

        FIX: begin
          if (!bus.div_init) begin
            state <= IDLE;
          end else begin
            bus.div_stop <= 1'b1;
            state        <= DONE;
`ifdef DIV_ZERO_DETECT_EN
            if (zero_pend) begin
              bus.div_zero <= 1'b1;
              zero_pend    <= 1'b0;
            end else begin
              bus.lo_out <= (sign_a ^ sign_b) ? (~q + 32'd1) : q;
              bus.hi_out <= sign_a ? (~r + 32'd1) : r;
            end
`else
            bus.lo_out <= (sign_a ^ sign_b) ? (~q + 32'd1) : q;
            bus.hi_out <= sign_a ? (~r + 32'd1) : r;
`endif
          end
        end

        DONE: begin
          bus.div_stop <= 1'b0;
          state        <= bus.div_init ? HOLD : IDLE;
        end

        HOLD: begin
          bus.div_stop <= 1'b0;
          if (!bus.div_init)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed and random divisions against a signed-arithmetic model.
module tb_div;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_if bus ();

  div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic        prev_z  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi, output logic z);
    longint sa, sb;
    z = 1'b0;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      lo = prev_lo;
      hi = prev_hi;
      z  = 1'b1;
`else
      lo = a[31] ? 32'd1 : 32'hFFFFFFFF;
      hi = a;
`endif
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    logic [31:0] elo, ehi;
    logic        ez;
    int          lat, stop_at, extra;
    model(a, b, elo, ehi, ez);
    lat = ez ? 1 : 33;
    @(negedge clk);
    bus.div_init = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    stop_at = 0;
    for (int k = 1; k <= 40 && stop_at == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
      if (bus.div_stop) stop_at = k;
    end
    check({tag, "_latency"}, 32'(stop_at), 32'(lat));
    check({tag, "_lo"}, bus.lo_out, elo);
    check({tag, "_hi"}, bus.hi_out, ehi);
    check({tag, "_zero"}, {31'd0, bus.div_zero}, {31'd0, ez});
    extra = 0;
    for (int j = 0; j < 1 + hold; j++) begin
      @(posedge clk);
      #1;
      if (bus.div_stop) extra++;
    end
    check({tag, "_extra_stop"}, 32'(extra), 32'd0);
    @(negedge clk);
    bus.div_init = 1'b0;
    prev_lo = elo;
    prev_hi = ehi;
    prev_z  = ez;
  endtask

  initial begin
    int stops;
    logic [31:0] ra, rb;

    reset        = 1'b0;
    bus.div_init = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stop", {31'd0, bus.div_stop}, 32'd0);
    check("rst_zero", {31'd0, bus.div_zero}, 32'd0);
    check("rst_hi", bus.hi_out, 32'd0);
    check("rst_lo", bus.lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32'd100, 32'd7, 50, "p100_d7_hold");
    run_op(32'hFFFFFF9C, 32'd7, 0, "n100_d7");
    run_op(32'd100, 32'hFFFFFFF9, 0, "p100_dn7");
    run_op(32'h80000000, 32'hFFFFFFFF, 0, "min_dneg1");
    run_op(32'd5, 32'd9, 0, "p5_d9");
    run_op(32'd9, 32'd3, 0, "p9_d3");
    run_op(32'd100, 32'd7, 0, "p100_d7");
    run_op(32'd42, 32'd0, 0, "p42_d0");
    run_op(32'hFFFFFFD6, 32'd0, 0, "n42_d0");
    run_op(32'h80000000, 32'd1, 0, "min_d1");
    run_op(32'h7FFFFFFF, 32'h80000000, 0, "max_dmin");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 20));
        1:       rb = -32'($urandom_range(1, 20));
        2:       rb = $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, 0, "random");
    end

    run_op(32'd100, 32'd7, 0, "pre_reset");
    @(negedge clk);
    bus.div_init = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_stop", {31'd0, bus.div_stop}, 32'd0);
    check("midrst_zero", {31'd0, bus.div_zero}, 32'd0);
    check("midrst_hi", bus.hi_out, 32'd0);
    check("midrst_lo", bus.lo_out, 32'd0);
    @(negedge clk);
    bus.div_init = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stops = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_stop) stops++;
    end
    check("midrst_no_stop", 32'(stops), 32'd0);
    check("midrst_hi_after", bus.hi_out, 32'd0);
    check("midrst_lo_after", bus.lo_out, 32'd0);
    prev_hi = '0;
    prev_lo = '0;
    prev_z  = 1'b0;

    run_op(32'd9, 32'd3, 0, "pre_abort");
    run_op(32'd100, 32'd7, 0, "pre_abort2");
    @(negedge clk);
    bus.div_init = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    bus.div_init = 1'b0;
    stops = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_stop) stops++;
    end
    check("abort_no_stop", 32'(stops), 32'd0);
    check("abort_hi", bus.hi_out, prev_hi);
    check("abort_lo", bus.lo_out, prev_lo);
    check("abort_zero", {31'd0, bus.div_zero}, {31'd0, prev_z});
    run_op(32'hFFFFFFF9, 32'd2, 0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
